cms_trace_stream_serializer: RTL and testbench
==============================================

Name: cms_trace_stream_serializer

Overview:
- Sits directly downstream of the continuous monitoring system's AXI-Stream master.
- Accepts one wide trace packet per handshake (instr, clk-delta, pc, performance counters) and buffers up to FIFO_DEPTH packets.
- Replays each packet as IN_WIDTH/OUT_WIDTH narrow beats toward the DMA/AXI interconnect and propagates tlast on the final beat.
- Also exposes occupancy and a sent-packet count for software.

Parameters:
- IN_WIDTH, 1024: width of the incoming packet; must be an integer multiple of OUT_WIDTH (elaboration-time $error otherwise).
- OUT_WIDTH, 64: width of each outgoing beat.
- FIFO_DEPTH, 4: packet entries buffered; power of two, at least 2.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- S_AXIS_tvalid  in  1  upstream packet valid.
- S_AXIS_tready  out  1  high when the FIFO is not full.
- S_AXIS_tdata  in  IN_WIDTH  wide trace packet.
- S_AXIS_tlast  in  1  upstream end-of-transfer marker.
- M_AXIS_tvalid  out  1  narrow beat valid.
- M_AXIS_tready  in  1  downstream ready.
- M_AXIS_tdata  out  OUT_WIDTH  current beat.
- M_AXIS_tlast  out  1  high on the last beat of a packet whose stored tlast=1.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  packets currently held.
- packets_sent  out  32  count of fully drained packets; wraps modulo 2^32.

Behaviour:
- BEATS = IN_WIDTH/OUT_WIDTH. Beat k carries S_AXIS_tdata[k*OUT_WIDTH +: OUT_WIDTH]; beat 0 (LSB slice, performance counters end) goes first.
- Reset (async assert, sync-released by the environment) clears:
  - write pointer, read pointer, count and beat index;
  - packets_sent.
  - Stored packet data is not cleared.
- Reset values of outputs: S_AXIS_tready=1, M_AXIS_tvalid=0, M_AXIS_tlast=0, M_AXIS_tdata=0, fifo_count=0, packets_sent=0.
- If reset asserts mid-packet, the partial packet is discarded, M_AXIS_tvalid drops in the same instant, and there is no resume after release.
- Push:
  - occurs when S_AXIS_tvalid & S_AXIS_tready; writes {tlast, tdata} at the write pointer, then the write pointer increments, wrapping at FIFO_DEPTH.
  - S_AXIS_tready = (count != FIFO_DEPTH), registered-state derived only, with no combinational path from M_AXIS_tready.
  - When full and a pop completes in the same cycle, no push is accepted that cycle; tready rises the next cycle.
- Output:
  - M_AXIS_tvalid = (count != 0).
  - M_AXIS_tdata = head entry slice[beat_idx], or 0 when empty.
  - M_AXIS_tlast = tvalid & (beat_idx == BEATS-1) & head.tlast.
- Latency: a packet pushed into an empty FIFO at edge N presents beat 0 with tvalid=1 after edge N (1 cycle).
- Beat handshake (M_AXIS_tvalid & M_AXIS_tready):
  - If beat_idx < BEATS-1, beat_idx increments.
  - Otherwise beat_idx returns to 0, the read pointer increments (wrap), the entry is popped and packets_sent increments.
- AXI stability: while tvalid & ~tready, tdata and tlast hold, because the head entry and beat_idx are unchanged.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- Empty with push: no bypass; the data appears the next cycle.
- count ranges 0..FIFO_DEPTH. Overflow and underflow are impossible by construction; assertions check that neither occurs.
- No state machine beyond beat_idx; the FIFO uses the count-based full/empty scheme.

Decomposition:
- The shared continuous_monitoring_system_pkg gains:
  - CMS_SERIAL_OUT_WIDTH (64);
  - CMS_SERIAL_FIFO_DEPTH (4);
  - localparam function cms_beats(in_w, out_w).
- IN_WIDTH defaults to AXI_DATA_WIDTH at instantiation.
- One natural sub-module: cms_packet_fifo (parameterised width/depth, push/pop/full/empty/count). The serializer wraps it with the beat counter, slice mux and packets_sent counter.

Test Plan (bench uses IN_WIDTH=256, OUT_WIDTH=64, FIFO_DEPTH=4):
- Single packet 0x4444..._3333..._2222..._1111... with tlast=1 and M_AXIS_tready=1 -> beats 0x1111..., 0x2222..., 0x3333..., 0x4444... on 4 consecutive cycles starting 1 cycle after the push; tlast only on beat 4; packets_sent=1; fifo_count returns to 0.
- M_AXIS_tready=0 held while 5 packets are offered -> 4 accepted, S_AXIS_tready=0, fifo_count=4, beat 0 of packet 1 stable throughout.
- In the full state, release tready for 4 beats -> on the cycle of the 4th beat (pop), S_AXIS_tready is still 0 and no push occurs; the next cycle tready=1 and packet 5 is accepted; the output order is packets 1..5.
- Random M_AXIS_tready (50%) over 100 packets with tlast pattern 0,0,1 -> 400 beats in order, tlast only on last beats of every third packet, packets_sent=100, and tdata/tlast never change while tvalid & ~tready.
- Assert rst after beat 2 of a packet with 3 queued -> tvalid=0 immediately, fifo_count=0, packets_sent=0; a fresh packet after release starts at beat 0.
- packets_sent preloaded via force to 0xFFFF_FFFF, then one packet drained -> packets_sent=0.

Source files
------------

// File: rtl/continuous_monitoring_system_pkg.sv
// Shared constants and helpers for the continuous monitoring system.
// The trace serializer pulls its default widths and depth from here.
package continuous_monitoring_system_pkg;

  localparam int unsigned AXI_DATA_WIDTH        = 1024;
  localparam int unsigned CMS_SERIAL_OUT_WIDTH  = 64;
  localparam int unsigned CMS_SERIAL_FIFO_DEPTH = 4;

  // Narrow beats needed to replay one wide packet; 0 flags a bad configuration.
  function automatic int unsigned cms_beats(input int unsigned in_w, input int unsigned out_w);
    if (out_w == 0) begin
      return 0;
    end
    return in_w / out_w;
  endfunction

endpackage

// File: rtl/cms_packet_fifo.sv
// Count-based packet FIFO: one wide entry per push, head entry visible on rdata.
// Storage is deliberately left out of reset; only pointers and count clear.
module cms_packet_fifo #(
  parameter int unsigned Width = 65,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));
  a_count_range:  assert property (@(posedge clk) disable iff (rst) count_q <= CntW'(Depth));

endmodule

// File: rtl/cms_trace_stream_serializer.sv
// Buffers wide trace packets and replays each as IN_WIDTH/OUT_WIDTH narrow AXI-Stream
// beats, LSB slice first, with tlast on the final beat of packets that carried tlast.
module cms_trace_stream_serializer
  import continuous_monitoring_system_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = AXI_DATA_WIDTH,
  parameter int unsigned OUT_WIDTH  = CMS_SERIAL_OUT_WIDTH,
  parameter int unsigned FIFO_DEPTH = CMS_SERIAL_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          S_AXIS_tvalid,
  output logic                          S_AXIS_tready,
  input  logic [IN_WIDTH-1:0]           S_AXIS_tdata,
  input  logic                          S_AXIS_tlast,
  output logic                          M_AXIS_tvalid,
  input  logic                          M_AXIS_tready,
  output logic [OUT_WIDTH-1:0]          M_AXIS_tdata,
  output logic                          M_AXIS_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [31:0]                   packets_sent
);

  localparam int unsigned BEATS  = cms_beats(IN_WIDTH, OUT_WIDTH);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (BEATS == 0 || (IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_width
    $error("IN_WIDTH must be a nonzero integer multiple of OUT_WIDTH");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  logic                              fifo_push, fifo_pop;
  logic                              fifo_full, fifo_empty;
  logic [IN_WIDTH:0]                 head;
  logic [BEATS-1:0][OUT_WIDTH-1:0]   head_beats;
  logic                              head_last;
  logic                              beat_hs, last_beat;
  logic [BEAT_W-1:0]                 beat_idx_q, beat_idx_d;
  logic [31:0]                       packets_sent_q, packets_sent_d;

  // A pop that frees the last slot does not open tready until the next cycle.
  assign S_AXIS_tready = ~fifo_full;
  assign fifo_push     = S_AXIS_tvalid & ~fifo_full;

  cms_packet_fifo #(
    .Width (IN_WIDTH + 1),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({S_AXIS_tlast, S_AXIS_tdata}),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_beats = head[IN_WIDTH-1:0];
  assign head_last  = head[IN_WIDTH];
  assign last_beat  = (beat_idx_q == BEAT_W'(BEATS - 1));

  assign M_AXIS_tvalid = ~fifo_empty;
  assign beat_hs       = M_AXIS_tvalid & M_AXIS_tready;
  assign fifo_pop      = beat_hs & last_beat;

  always_comb begin
    M_AXIS_tdata = '0;
    if (!fifo_empty) begin
      M_AXIS_tdata = head_beats[beat_idx_q];
    end
  end

  assign M_AXIS_tlast = M_AXIS_tvalid & last_beat & head_last;
  assign packets_sent = packets_sent_q;

  always_comb begin
    beat_idx_d     = beat_idx_q;
    packets_sent_d = packets_sent_q;
    if (beat_hs) begin
      if (last_beat) begin
        beat_idx_d     = '0;
        packets_sent_d = packets_sent_q + 32'd1;
      end else begin
        beat_idx_d = beat_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_idx_q     <= '0;
      packets_sent_q <= '0;
    end else begin
      beat_idx_q     <= beat_idx_d;
      packets_sent_q <= packets_sent_d;
    end
  end

  // Stalled beats must hold steady until accepted.
  a_stable_stall: assert property (@(posedge clk) disable iff (rst)
    (M_AXIS_tvalid && !M_AXIS_tready) |=> (M_AXIS_tvalid && $stable(M_AXIS_tdata)
                                            && $stable(M_AXIS_tlast)));
  a_tlast_valid:  assert property (@(posedge clk) disable iff (rst)
    M_AXIS_tlast |-> M_AXIS_tvalid);

endmodule

// File: tb/tb_cms_trace_stream_serializer.sv
// Scoreboard bench for the trace serializer: packets are split into expected beats when
// accepted, and a monitor pops and compares on every output handshake.
module tb_cms_trace_stream_serializer;

  localparam int unsigned IW = 256;
  localparam int unsigned OW = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NB = IW / OW;

  typedef struct packed {
    logic [OW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_tvalid, s_tready, s_tlast;
  logic [IW-1:0] s_tdata;
  logic          m_tvalid, m_tready, m_tlast;
  logic [OW-1:0] m_tdata;
  logic [2:0]    fifo_count;
  logic [31:0]   packets_sent;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    beats_seen = 0;
  bit    rand_done;

  always #5 clk = ~clk;

  cms_trace_stream_serializer #(
    .IN_WIDTH   (IW),
    .OUT_WIDTH  (OW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .S_AXIS_tvalid (s_tvalid),
    .S_AXIS_tready (s_tready),
    .S_AXIS_tdata  (s_tdata),
    .S_AXIS_tlast  (s_tlast),
    .M_AXIS_tvalid (m_tvalid),
    .M_AXIS_tready (m_tready),
    .M_AXIS_tdata  (m_tdata),
    .M_AXIS_tlast  (m_tlast),
    .fifo_count    (fifo_count),
    .packets_sent  (packets_sent)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a packet becomes NB slices, LSB first, tlast only on the last slice.
  task automatic model_push(input logic [IW-1:0] d, input logic l);
    beat_t b;
    for (int k = 0; k < NB; k++) begin
      b.data = d[k*OW +: OW];
      b.last = l && (k == NB - 1);
      exp_q.push_back(b);
    end
  endtask

  function automatic logic [IW-1:0] rand_pkt();
    logic [IW-1:0] r;
    for (int k = 0; k < IW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Called and returns at #1 after a rising edge.
  task automatic send_pkt(input logic [IW-1:0] d, input logic l);
    bit done = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (s_tready) begin
        model_push(d, l);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    if (!done) check("push_timeout", 64'(done), 64'd1);
  endtask

  task automatic wait_drain();
    bit drained = 1'b0;
    for (int i = 0; i < 3000 && !drained; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_tvalid) drained = 1'b1;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard compare on handshakes, hold check on stalls, idle output check.
  initial begin
    logic          stall_prev = 1'b0;
    logic [OW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    beat_t         e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid", 64'(m_tvalid), 64'd1);
          check("stall_data", m_tdata, prev_data);
          check("stall_last", 64'(m_tlast), 64'(prev_last));
        end
        if (!m_tvalid) begin
          check("idle_data", m_tdata, 64'd0);
          check("idle_last", 64'(m_tlast), 64'd0);
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", m_tdata, 64'(exp_q.size()));
          end else begin
            e = exp_q.pop_front();
            check("beat_data", m_tdata, e.data);
            check("beat_last", 64'(m_tlast), 64'(e.last));
          end
          beats_seen++;
        end
        stall_prev = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
      end
    end
  end

  initial begin
    logic [IW-1:0] p1, p5, fresh;
    int            base;
    rst = 1'b1;
    s_tvalid = 1'b0;
    s_tdata = '0;
    s_tlast = 1'b0;
    m_tready = 1'b0;
    rand_done = 1'b0;

    #12;
    check("rst_s_tready", 64'(s_tready), 64'd1);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tlast", 64'(m_tlast), 64'd0);
    check("rst_m_tdata", m_tdata, 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_sent", 64'(packets_sent), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single packet, 1-cycle latency, four back-to-back beats.
    m_tready = 1'b1;
    send_pkt({{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 1'b1);
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      check("t1_valid", 64'(m_tvalid), 64'd1);
      check("t1_last", 64'(m_tlast), 64'(k == NB - 1));
    end
    @(negedge clk);
    check("t1_empty_valid", 64'(m_tvalid), 64'd0);
    check("t1_count", 64'(fifo_count), 64'd0);
    check("t1_sent", 64'(packets_sent), 64'd1);
    @(posedge clk);
    #1;

    // Fill with output stalled.
    m_tready = 1'b0;
    p1 = rand_pkt();
    send_pkt(p1, 1'b0);
    for (int i = 0; i < 3; i++) send_pkt(rand_pkt(), 1'(i == 2));
    @(negedge clk);
    check("full_s_tready", 64'(s_tready), 64'd0);
    check("full_count", 64'(fifo_count), 64'd4);
    check("full_head", m_tdata, p1[OW-1:0]);
    @(posedge clk);
    #1;

    // Packet 5 offered while full; pop of packet 1 must not admit it in the same cycle.
    p5 = rand_pkt();
    fork
      send_pkt(p5, 1'b1);
      begin
        repeat (3) begin
          @(negedge clk);
          check("t2_head_hold", m_tdata, p1[OW-1:0]);
          check("t2_count_hold", 64'(fifo_count), 64'd4);
        end
        @(posedge clk);
        #1 m_tready = 1'b1;
        repeat (3) @(negedge clk);
        @(negedge clk);
        check("t3_pop_cycle_tready", 64'(s_tready), 64'd0);
        @(posedge clk);
        #1 m_tready = 1'b0;
        @(negedge clk);
        check("t3_after_pop_tready", 64'(s_tready), 64'd1);
        check("t3_after_pop_count", 64'(fifo_count), 64'd3);
      end
    join
    m_tready = 1'b1;
    wait_drain();
    check("t3_sent", 64'(packets_sent), 64'd6);

    // Random backpressure over 100 packets, tlast on every third.
    base = beats_seen;
    fork
      begin
        for (int i = 0; i < 100; i++) send_pkt(rand_pkt(), 1'(i % 3 == 2));
        rand_done = 1'b1;
      end
      while (!rand_done) begin
        @(posedge clk);
        #1 m_tready = 1'($urandom_range(0, 1));
      end
    join
    m_tready = 1'b1;
    wait_drain();
    check("t4_beats", 64'(beats_seen - base), 64'd400);
    check("t4_sent", 64'(packets_sent), 64'd106);

    // Reset mid-packet with three queued.
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) send_pkt(rand_pkt(), 1'b1);
    m_tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_tready = 1'b0;
    #1;
    check("t5_valid", 64'(m_tvalid), 64'd0);
    check("t5_count", 64'(fifo_count), 64'd0);
    check("t5_sent", 64'(packets_sent), 64'd0);
    check("t5_tready", 64'(s_tready), 64'd1);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    m_tready = 1'b1;
    fresh = rand_pkt();
    send_pkt(fresh, 1'b1);
    @(negedge clk);
    check("t5_fresh_valid", 64'(m_tvalid), 64'd1);
    check("t5_fresh_beat0", m_tdata, fresh[OW-1:0]);
    @(posedge clk);
    #1;
    wait_drain();
    check("t5_fresh_sent", 64'(packets_sent), 64'd1);

    // packets_sent wraps modulo 2^32.
    force dut.packets_sent_q = 32'hFFFF_FFFF;
    #1;
    release dut.packets_sent_q;
    check("t6_preload", 64'(packets_sent), 64'hFFFF_FFFF);
    @(posedge clk);
    #1;
    send_pkt(rand_pkt(), 1'b0);
    wait_drain();
    check("t6_wrap", 64'(packets_sent), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
